// File: rtl/bcd_reaction_ctr_if.sv
// Counter-control link between the reaction-timer game FSM and the BCD elapsed-time counter.
// The controller drives enable/clear; the counter returns the displayed digits and status.
interface bcd_reaction_ctr_if;
    logic       ctr_en;
    logic       ctr_ar;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_hund;
    logic       ovf;
    logic       done;

    modport master (
        output ctr_en,
        output ctr_ar,
        input  bcd_ones,
        input  bcd_tens,
        input  bcd_hund,
        input  ovf,
        input  done
    );

    modport slave (
        input  ctr_en,
        input  ctr_ar,
        output bcd_ones,
        output bcd_tens,
        output bcd_hund,
        output ovf,
        output done
    );
endinterface

// File: rtl/bcd_reaction_ctr.sv
// Three-digit BCD elapsed-time counter: counts prescaled ticks 000..999 with sticky overflow
// and a one-cycle done pulse on the falling edge of the controller's count enable.
module bcd_reaction_ctr #(
    parameter int TICK_DIV = 10000,
    parameter int PSC_W    = 14
) (
    input  logic               clk,
    input  logic               ar,
    bcd_reaction_ctr_if.slave  cif
);

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             en_dly_q;
    logic             en_dly_d;
    logic             done_q;
    logic             done_d;

    logic             psc_wrap;
    logic             tick;
    logic [3:0]       carry;
    logic [2:0][3:0]  digits;

    assign psc_wrap = (psc_q == PSC_LAST);
    assign tick     = cif.ctr_ar & cif.ctr_en & ~ovf_q & psc_wrap;
    assign carry[0] = tick;

    // carry[3] means the increment would pass 999: every digit holds and ovf is set instead.
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
        logic [3:0] digit_q;
        logic [3:0] digit_d;
        logic       at_nine;

        assign at_nine       = (digit_q == 4'd9);
        assign carry[gi+1]   = carry[gi] & at_nine;
        assign digits[gi]    = digit_q;

        always_comb begin
            digit_d = digit_q;
            if (!cif.ctr_ar) begin
                digit_d = 4'd0;
            end else if (carry[gi] && !carry[3]) begin
                digit_d = at_nine ? 4'd0 : digit_q + 4'd1;
            end
        end

        always_ff @(posedge clk or posedge ar) begin
            if (ar) begin
                digit_q <= 4'd0;
            end else begin
                digit_q <= digit_d;
            end
        end
    end

    always_comb begin
        psc_d    = psc_q;
        ovf_d    = ovf_q;
        en_dly_d = cif.ctr_en;
        done_d   = en_dly_q & ~cif.ctr_en & cif.ctr_ar;
        if (!cif.ctr_ar) begin
            psc_d    = '0;
            ovf_d    = 1'b0;
            en_dly_d = 1'b0;
            done_d   = 1'b0;
        end else if (cif.ctr_en && !ovf_q) begin
            if (psc_wrap) begin
                psc_d = '0;
                if (carry[3]) begin
                    ovf_d = 1'b1;
                end
            end else begin
                psc_d = psc_q + PSC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            psc_q    <= '0;
            ovf_q    <= 1'b0;
            en_dly_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            psc_q    <= psc_d;
            ovf_q    <= ovf_d;
            en_dly_q <= en_dly_d;
            done_q   <= done_d;
        end
    end

    assign cif.bcd_ones = digits[0];
    assign cif.bcd_tens = digits[1];
    assign cif.bcd_hund = digits[2];
    assign cif.ovf      = ovf_q;
    assign cif.done     = done_q;

endmodule

// File: tb/tb_bcd_reaction_ctr.sv
// Directed bench for bcd_reaction_ctr: one instance with TICK_DIV=1, one with TICK_DIV=4,
// sharing clock and reset.
module tb_bcd_reaction_ctr;

    logic clk;
    logic ar;
    int   checks;
    int   failures;

    bcd_reaction_ctr_if a1 ();
    bcd_reaction_ctr_if a4 ();

    bcd_reaction_ctr #(.TICK_DIV(1), .PSC_W(1)) dut1 (
        .clk (clk),
        .ar  (ar),
        .cif (a1.slave)
    );

    bcd_reaction_ctr #(.TICK_DIV(4), .PSC_W(2)) dut4 (
        .clk (clk),
        .ar  (ar),
        .cif (a4.slave)
    );

    logic [11:0] v1;
    logic [11:0] v4;
    assign v1 = {a1.bcd_hund, a1.bcd_tens, a1.bcd_ones};
    assign v4 = {a4.bcd_hund, a4.bcd_tens, a4.bcd_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("chk  %s: got %0h", tag, act);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        checks   = 0;
        failures = 0;
        ar       = 1'b1;
        a1.ctr_en = 1'b0; a1.ctr_ar = 1'b1;
        a4.ctr_en = 1'b0; a4.ctr_ar = 1'b1;
        step(2);
        check("rst_val1", 32'(v1), 32'h000);
        check("rst_ovf1", 32'(a1.ovf), 0);
        check("rst_done4", 32'(a4.done), 0);
        ar = 1'b0;
        step(1);

        // 1: asynchronous reset mid-count
        a1.ctr_ar = 1'b0; step(1);
        a1.ctr_ar = 1'b1; a1.ctr_en = 1'b1;
        step(123);
        check("t1_count", 32'(v1), 32'h123);
        #2 ar = 1'b1;
        #1;
        check("t1_async_val", 32'(v1), 32'h000);
        check("t1_async_ovf", 32'(a1.ovf), 0);
        check("t1_async_done", 32'(a1.done), 0);
        step(2);
        check("t1_hold_val", 32'(v1), 32'h000);
        a1.ctr_en = 1'b0;
        ar = 1'b0;
        step(1);

        // 2: basic count with prescaler of 4
        a4.ctr_ar = 1'b0; step(1);
        a4.ctr_ar = 1'b1; a4.ctr_en = 1'b1;
        step(40);
        check("t2_val", 32'(v4), 32'h010);
        a4.ctr_en = 1'b0;
        step(1);
        check("t2_done_hi", 32'(a4.done), 1);
        step(1);
        check("t2_done_lo", 32'(a4.done), 0);
        check("t2_val_hold", 32'(v4), 32'h010);

        // 3: carry chain
        a1.ctr_ar = 1'b0; step(1);
        a1.ctr_ar = 1'b1; a1.ctr_en = 1'b1;
        step(99);
        check("t3_099", 32'(v1), 32'h099);
        step(1);
        check("t3_100", 32'(v1), 32'h100);

        // 4: saturation at 999
        a1.ctr_ar = 1'b0; step(1);
        a1.ctr_ar = 1'b1;
        step(999);
        check("t4_999", 32'(v1), 32'h999);
        check("t4_ovf_pre", 32'(a1.ovf), 0);
        step(1);
        check("t4_ovf_1000", 32'(a1.ovf), 1);
        check("t4_sat_1000", 32'(v1), 32'h999);
        step(5);
        check("t4_sat_1005", 32'(v1), 32'h999);
        a1.ctr_en = 1'b0;
        step(1);
        check("t4_done_ovf", 32'(a1.done), 1);
        check("t4_ovf_sticky", 32'(a1.ovf), 1);
        a1.ctr_ar = 1'b0; a1.ctr_en = 1'b1;
        step(1);
        check("t4_clr_val", 32'(v1), 32'h000);
        check("t4_clr_ovf", 32'(a1.ovf), 0);
        a1.ctr_en = 1'b0; a1.ctr_ar = 1'b1;
        step(1);

        // 5: pause/resume keeps the partial tick
        a4.ctr_ar = 1'b0; step(1);
        a4.ctr_ar = 1'b1; a4.ctr_en = 1'b1;
        step(6);
        check("t5_pre_pause", 32'(v4), 32'h001);
        a4.ctr_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (a4.done) pulses++;
        end
        check("t5_done_once", 32'(pulses), 1);
        check("t5_pause_val", 32'(v4), 32'h001);
        a4.ctr_en = 1'b1;
        step(2);
        check("t5_resume_val", 32'(v4), 32'h002);
        a4.ctr_en = 1'b0;
        step(2);

        // 6: clear wins over enable; no done while clearing
        a1.ctr_ar = 1'b0; step(1);
        a1.ctr_ar = 1'b1; a1.ctr_en = 1'b1;
        step(5);
        check("t6_005", 32'(v1), 32'h005);
        a1.ctr_ar = 1'b0;
        step(1);
        check("t6_clr_en", 32'(v1), 32'h000);
        a1.ctr_ar = 1'b1;
        step(2);
        check("t6_recount", 32'(v1), 32'h002);
        a1.ctr_en = 1'b0; a1.ctr_ar = 1'b0;
        step(1);
        check("t6_no_done_clr", 32'(a1.done), 0);
        check("t6_clr_val", 32'(v1), 32'h000);
        a1.ctr_ar = 1'b1;
        step(1);
        check("t6_no_done_after", 32'(a1.done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_reaction_ctr.md
# bcd_reaction_ctr

Three-digit BCD elapsed-time counter for the reaction-timer game. It is the downstream end of the counter-control interface: it consumes the count-enable and active-low clear produced by the game state machine and counts prescaled ticks (1 ms at the 10 MHz system clock by default) from 000 to 999. It drives the display digits, a sticky overflow flag, and a one-cycle `done` pulse when a measurement ends.

## Interface

- `TICK_DIV`, 10000: enabled clock cycles per count increment; legal range 1 to 2^PSC_W.
- `PSC_W`, 14: prescaler width; must satisfy 2^PSC_W >= TICK_DIV.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `ar`  in  1  reset; one clock; reset is asynchronous and active-high.
- `ctr_en`  in  1  count enable from the controller; high while the game is running.
- `ctr_ar`  in  1  counter clear from the controller, active-low; sampled synchronously.
- `bcd_ones`  out  4  units digit, 0–9.
- `bcd_tens`  out  4  tens digit, 0–9.
- `bcd_hund`  out  4  hundreds digit, 0–9.
- `ovf`  out  1  sticky flag; set when the count tries to pass 999.
- `done`  out  1  one-cycle pulse marking the end of a measurement.

## Operation

- State:
  - prescaler `psc` (PSC_W bits);
  - three BCD digit registers;
  - `ovf` register;
  - `en_d`, which holds `ctr_en` delayed by one cycle;
  - `done` register.
- Priority on each rising edge: `ar` first, then clear (`ctr_ar`=0), then enable (`ctr_en`=1), then hold.
- Reset (`ar`=1, asynchronous):
  - `psc`=0, all digits 0, `ovf`=0, `en_d`=0, `done`=0.
  - Takes effect immediately, independent of `clk`, including mid-count.
- Clear (`ctr_ar`=0):
  - `psc`=0, digits 000, `ovf`=0, `done`=0, `en_d`=0.
  - No increment that cycle, even if `ctr_en`=1.
- Enable (`ctr_en`=1, `ctr_ar`=1, `ovf`=0):
  - If `psc`==TICK_DIV-1: `psc` goes to 0 and the digits increment.
  - Otherwise `psc` increments by 1.
- Increment rules:
  - Ones 9 wraps to 0 and carries into tens.
  - Tens 9 wraps to 0 and carries into hundreds.
  - An increment at 999 leaves the digits at 999 and sets `ovf`=1.
- Overflow:
  - While `ovf`=1, `psc` and the digits hold regardless of `ctr_en`.
  - `ovf` clears only on clear or reset.
- Disabled (`ctr_en`=0, `ctr_ar`=1):
  - `psc`, digits and `ovf` hold.
  - A resumed enable continues the partial tick; the prescaler is not reset on pause.
- `done`:
  - Registered as `en_d & ~ctr_en & ctr_ar`, so it pulses for exactly one cycle on the falling edge of `ctr_en`.
  - Pulses even when `ovf`=1.
  - Never pulses on a cycle where a clear is asserted.
- Digits never hold values 10–15.

## Timing

- All outputs are registered; no combinational path from input to output.
- After `k` enabled, non-overflowed edges since the last clear, displayed value = min(floor(k/TICK_DIV), 999).
- With TICK_DIV=1 the count advances on every enabled edge.
- Digits change on the same edge on which `psc` wraps and are visible immediately after it.
- `ovf` rises on the edge of the 1000th tick.
- `done` is high for the single cycle after the first edge that samples `ctr_en`=0 following `ctr_en`=1.
- Controller sequencing tolerated:
  - Clear for one or more cycles, then enable.
  - Clear and enable asserted together is legal; clear wins.

## Test plan

1. Reset mid-operation: TICK_DIV=1, count to 123, assert `ar` between clock edges -> digits 0/0/0, `ovf`=0, `done`=0 before the next edge; values hold while `ar`=1.
2. Basic count: TICK_DIV=4, one clear cycle, `ctr_en`=1 for 40 edges then 0 -> digits 0/1/0; `done`=1 for exactly one cycle after the first disabled edge, then 0.
3. Carry chain: TICK_DIV=1, 99 enabled edges -> 0/9/9; one more edge -> 1/0/0.
4. Saturation: TICK_DIV=1, 1005 enabled edges -> 9/9/9 with `ovf`=1 from edge 1000 onward; then `ctr_ar`=0 for one edge -> 0/0/0, `ovf`=0.
5. Pause/resume: TICK_DIV=4, enable 6 edges, disable 10, enable 2 -> value 002 (8 enabled edges); `done` pulses once at the pause, and the value stays 001 during the pause.
6. Simultaneous events: at count 005, drive `ctr_ar`=0 and `ctr_en`=1 on the same edge -> 000, no increment. Then drive `ctr_en` 1->0 together with `ctr_ar`=0 -> no `done` pulse.
